// File: rtl/keccak_pkg.sv
// Shared keccak constants: lane width, rate, squeeze words per rate block, squeeze FSM states.
// Rate must be a whole number of lanes; RATE_WORDS_OK fails elaboration (divide by zero) otherwise.
package keccak_pkg;

   localparam int W         = 64;
   localparam int RATE      = 1088;
   localparam int SQZ_DEPTH = RATE / W;

   localparam int RATE_WORDS_OK = 1 / (((RATE % W) == 0) ? 1 : 0);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_BLOCK = 2'd1,
      SHIFT      = 2'd2
   } squeeze_state_t;

endpackage

// File: rtl/keccak_squeeze_piso.sv
// Squeeze PISO: emits rate blocks as WIDTH-bit words, 1 cycle after the block handshake, holding a word while data_ready_in is low; pulses squeeze_req_out for more blocks.
// KECCAK_SQUEEZE_MASK_LAST_EN zeroes the unused upper bits of a partial final word.
module keccak_squeeze_piso
   import keccak_pkg::*;
#(
   parameter int WIDTH  = W,
   parameter int DEPTH  = SQZ_DEPTH,
   parameter int SIZE_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     size_valid_in,
   input  logic [SIZE_W-1:0]        size_in,
   output logic                     size_ready_out,
   input  logic                     block_valid_in,
   input  logic [WIDTH*DEPTH-1:0]   block_in,
   output logic                     block_ready_out,
   output logic                     squeeze_req_out,
   output logic                     data_valid_out,
   output logic [WIDTH-1:0]         data_out,
   output logic                     data_last_out,
   input  logic                     data_ready_in,
   output logic                     busy_out
);

   localparam int LOG_W = $clog2(WIDTH);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   if (RATE_WORDS_OK != 1 || DEPTH < 2) begin : g_bad_cfg
      $error("keccak_squeeze_piso: rate must be a multiple of w and DEPTH must be >= 2");
   end

   squeeze_state_t state, state_nxt;

   logic [WIDTH*DEPTH-1:0] shift_reg;
   logic [IDX_W-1:0]       word_idx;
   logic [SIZE_W-1:0]      remaining;
   logic [SIZE_W-1:0]      size_words;
   logic                   sqz_pulse;
   logic                   cmd_fire;
   logic                   blk_fire;
   logic                   xfer;
   logic                   last_word;

   // ceil(size_in / WIDTH) without widening: quotient plus one if any tail bits
   assign size_words = (size_in >> LOG_W) + SIZE_W'(|size_in[LOG_W-1:0]);

   assign last_word = (remaining == SIZE_W'(1));
   assign cmd_fire  = size_valid_in  && size_ready_out;
   assign blk_fire  = block_valid_in && block_ready_out;
   assign xfer      = data_valid_out && data_ready_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      size_ready_out  = 1'b0;
      block_ready_out = 1'b0;
      data_valid_out  = 1'b0;
      case (state)
         IDLE: begin
            size_ready_out = 1'b1;
            if (size_valid_in && size_words != '0) begin
               state_nxt = WAIT_BLOCK;
            end
         end
         WAIT_BLOCK: begin
            block_ready_out = 1'b1;
            if (block_valid_in) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            data_valid_out = 1'b1;
            // final word wins over block end, so no extra permutation is requested
            if (data_ready_in) begin
               if (last_word) begin
                  state_nxt = IDLE;
               end else if (word_idx == LAST_IDX) begin
                  state_nxt = WAIT_BLOCK;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         word_idx  <= '0;
         remaining <= '0;
         sqz_pulse <= 1'b0;
      end else begin
         sqz_pulse <= xfer && !last_word && (word_idx == LAST_IDX);
         if (cmd_fire) begin
            remaining <= size_words;
         end
         if (blk_fire) begin
            shift_reg <= block_in;
            word_idx  <= '0;
         end else if (xfer) begin
            shift_reg <= shift_reg >> WIDTH;
            remaining <= remaining - 1'b1;
            word_idx  <= word_idx + 1'b1;
         end
      end
   end

   assign squeeze_req_out = sqz_pulse;
   assign data_last_out   = (state == SHIFT) && last_word;
   assign busy_out        = (state != IDLE);

`ifdef KECCAK_SQUEEZE_MASK_LAST_EN
   logic [LOG_W-1:0] tail_bits;
   logic [WIDTH-1:0] tail_mask;

   always_ff @(posedge clk) begin
      if (rst) begin
         tail_bits <= '0;
      end else if (cmd_fire) begin
         tail_bits <= size_in[LOG_W-1:0];
      end
   end

   always_comb begin
      tail_mask = '1;
      if (data_last_out && tail_bits != '0) begin
         tail_mask = ~({WIDTH{1'b1}} << tail_bits);
      end
   end

   assign data_out = shift_reg[WIDTH-1:0] & tail_mask;
`else
   assign data_out = shift_reg[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_keccak_squeeze_piso.sv
// Directed bench for keccak_squeeze_piso: word order, last flag, squeeze pulses, stalls, zero-length and reset.
module tb_keccak_squeeze_piso;

   localparam int WD = 64;
   localparam int DP = 17;
   localparam int SW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              size_valid_in;
   logic [SW-1:0]     size_in;
   logic              size_ready_out;
   logic              block_valid_in;
   logic [WD*DP-1:0]  block_in;
   logic              block_ready_out;
   logic              squeeze_req_out;
   logic              data_valid_out;
   logic [WD-1:0]     data_out;
   logic              data_last_out;
   logic              data_ready_in;
   logic              busy_out;

   int n_vec = 0;
   int n_err = 0;
   bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   keccak_squeeze_piso #(.WIDTH(WD), .DEPTH(DP), .SIZE_W(SW)) dut (
      .clk             (clk),
      .rst             (rst),
      .size_valid_in   (size_valid_in),
      .size_in         (size_in),
      .size_ready_out  (size_ready_out),
      .block_valid_in  (block_valid_in),
      .block_in        (block_in),
      .block_ready_out (block_ready_out),
      .squeeze_req_out (squeeze_req_out),
      .data_valid_out  (data_valid_out),
      .data_out        (data_out),
      .data_last_out   (data_last_out),
      .data_ready_in   (data_ready_in),
      .busy_out        (busy_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // block b, word k = {hi, b*256 + k + 1}
   function automatic logic [WD*DP-1:0] mk_block(input int b, input logic [31:0] hi);
      logic [WD*DP-1:0] blk;
      blk = '0;
      for (int k = 0; k < DP; k++) begin
         blk[k*WD +: WD] = {hi, 32'(b * 256 + k + 1)};
      end
      return blk;
   endfunction

   function automatic logic [63:0] exp_word(input int idx, input logic [31:0] hi,
                                            input int n_words, input int size);
      logic [63:0] v;
      v = {hi, 32'((idx / DP) * 256 + (idx % DP) + 1)};
`ifdef KECCAK_SQUEEZE_MASK_LAST_EN
      if (idx == n_words - 1 && (size % WD) != 0) begin
         v = v & ((64'h1 << (size % WD)) - 64'h1);
      end
`endif
      return v;
   endfunction

   task automatic do_req(input string tag, input int size, input int mode,
                         input logic [31:0] hi, input int n_exp, input int sqz_exp);
      logic [63:0] words [$];
      logic [63:0] prev_d;
      logic        prev_l;
      bit          prev_stall;
      bit          done;
      int          n_sqz;
      int          n_blk;
      int          n_last;
      int          last_at;
      size_in       = SW'(size);
      size_valid_in = 1'b1;
      chk($sformatf("%s_cmd_rdy", tag), 64'(size_ready_out), 64'd1);
      @(posedge clk); #1;
      size_valid_in = 1'b0;
      prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
      done = 1'b0; n_sqz = 0; n_blk = 0; n_last = 0; last_at = -1;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         if (squeeze_req_out) n_sqz++;
         if (prev_stall) begin
            chk($sformatf("%s_hold_d%0d", tag, cyc), data_out, prev_d);
            chk($sformatf("%s_hold_l%0d", tag, cyc), 64'(data_last_out), 64'(prev_l));
         end
         data_ready_in  = (mode == 0) ? 1'b1 : pat[cyc % 6];
         block_in       = mk_block(n_blk, hi);
         block_valid_in = block_ready_out && (n_blk < 1 + n_sqz);
         if (block_valid_in) n_blk++;
         if (data_valid_out && data_ready_in) begin
            words.push_back(data_out);
            if (data_last_out) begin
               n_last++;
               last_at = words.size() - 1;
               done = 1'b1;
            end
         end
         prev_stall = data_valid_out && !data_ready_in;
         prev_d     = data_out;
         prev_l     = data_last_out;
         @(posedge clk); #1;
      end
      block_valid_in = 1'b0;
      data_ready_in  = 1'b0;
      chk($sformatf("%s_done", tag), 64'(done), 64'd1);
      chk($sformatf("%s_nwords", tag), 64'(words.size()), 64'(n_exp));
      for (int i = 0; i < words.size() && i < n_exp; i++) begin
         chk($sformatf("%s_w%0d", tag, i), words[i], exp_word(i, hi, n_exp, size));
      end
      chk($sformatf("%s_last_at", tag), 64'(last_at), 64'(n_exp - 1));
      chk($sformatf("%s_nlast", tag), 64'(n_last), 64'd1);
      chk($sformatf("%s_nsqz", tag), 64'(n_sqz), 64'(sqz_exp));
      chk($sformatf("%s_nblk", tag), 64'(n_blk), 64'(sqz_exp + 1));
      chk($sformatf("%s_idle_busy", tag), 64'(busy_out), 64'd0);
      chk($sformatf("%s_idle_srdy", tag), 64'(size_ready_out), 64'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_srdy"}, 64'(size_ready_out), 64'd1);
      chk({tag, "_brdy"}, 64'(block_ready_out), 64'd0);
      chk({tag, "_sqz"}, 64'(squeeze_req_out), 64'd0);
      chk({tag, "_vld"}, 64'(data_valid_out), 64'd0);
      chk({tag, "_last"}, 64'(data_last_out), 64'd0);
      chk({tag, "_dat"}, data_out, 64'd0);
      chk({tag, "_busy"}, 64'(busy_out), 64'd0);
   endtask

   initial begin
      int n_xfer;
      rst = 1'b1;
      size_valid_in = 1'b0; size_in = '0;
      block_valid_in = 1'b0; block_in = '0;
      data_ready_in = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk_idle("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      do_req("s256",  256,  0, 32'h0000_0000, 4,  0);
      do_req("s1088", 1088, 0, 32'h0BAD_F00D, 17, 0);
      do_req("s1152", 1152, 0, 32'h0000_0000, 18, 1);
      do_req("stall", 256,  1, 32'h1234_5678, 4,  0);

      // zero length: accepted, never asks for a block, never busy
      size_in = '0; size_valid_in = 1'b1;
      chk("z_cmd_rdy", 64'(size_ready_out), 64'd1);
      @(posedge clk); #1;
      size_valid_in = 1'b0;
      block_valid_in = 1'b1; block_in = mk_block(0, 32'hFFFF_FFFF);
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("z_busy%0d", c), 64'(busy_out), 64'd0);
         chk($sformatf("z_brdy%0d", c), 64'(block_ready_out), 64'd0);
         chk($sformatf("z_vld%0d", c), 64'(data_valid_out), 64'd0);
         @(posedge clk); #1;
      end
      block_valid_in = 1'b0;

      // reset after two words of a four-word request
      size_in = SW'(256); size_valid_in = 1'b1;
      @(posedge clk); #1;
      size_valid_in = 1'b0;
      n_xfer = 0;
      for (int c = 0; c < 50 && n_xfer < 2; c++) begin
         data_ready_in  = 1'b1;
         block_in       = mk_block(0, 32'h0000_0000);
         block_valid_in = block_ready_out;
         if (data_valid_out) n_xfer++;
         @(posedge clk); #1;
      end
      block_valid_in = 1'b0; data_ready_in = 1'b0;
      chk("mid_busy", 64'(busy_out), 64'd1);
      chk("mid_w3", data_out, 64'd3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_idle("midrst");
      do_req("s100", 100, 0, 32'hDEAD_BEEF, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
